// File: rtl/dht11_pkg.sv
// Shared state encoding and default timing constants for the DHT11 measurement sequencer.
package dht11_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int DEF_TICK_DIV   = 100_000;
  localparam int DEF_PERIOD_MS  = 2000;
  localparam int DEF_GAP_MS     = 1000;
  localparam int DEF_TIMEOUT_MS = 50;
  localparam int DEF_MAX_RETRY  = 3;

  // Millisecond counters are 16 bits wide, enough for any realistic period, gap or timeout.
  localparam int MS_W = 16;

endpackage

// File: rtl/dht11_scheduler_ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 while enabled and flags the terminal count.
module ms_tick_gen
  import dht11_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TERM) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == TERM);

endmodule

// File: rtl/dht11_scheduler.sv
// Measurement sequencer for dht11_controller: auto/manual scheduling, inter-read gap,
// transaction timeout with retries, and a hold register for the last good RH/T bytes.
module dht11_scheduler
  import dht11_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int PERIOD_MS  = DEF_PERIOD_MS,
  parameter int GAP_MS     = DEF_GAP_MS,
  parameter int TIMEOUT_MS = DEF_TIMEOUT_MS,
  parameter int MAX_RETRY  = DEF_MAX_RETRY
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           manual_req,
  input  logic                           auto_en,
  input  logic                           dht11_done,
  input  logic                           dht11_valid,
  input  logic [7:0]                     rh_in,
  input  logic [7:0]                     t_in,
  output logic                           dht11_start,
  output logic [7:0]                     rh_data,
  output logic [7:0]                     t_data,
  output logic                           data_valid,
  output logic                           new_data,
  output logic                           err_flag,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
  output logic                           busy
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0]   RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [MS_W-1:0] GAP_END    = MS_W'(GAP_MS - 1);
  localparam logic [MS_W-1:0] TMO_END    = MS_W'(TIMEOUT_MS - 1);
  localparam logic [MS_W-1:0] PERIOD_END = MS_W'(PERIOD_MS - 1);

  state_t state, next_state;

  logic            state_change;
  logic            fsm_tick;
  logic            p_tick;
  logic [MS_W-1:0] ms_cnt;
  logic [MS_W-1:0] p_ms;
  logic            period_fire;
  logic            gap_done;
  logic            timeout;
  logic            good_read;
  logic            bad_read;
  logic            can_retry;
  logic            pending;

  logic            start_d;
  logic            busy_d;
  logic            new_d;
  logic            valid_d;
  logic            err_d;
  logic            pending_d;
  logic [7:0]      rh_d;
  logic [7:0]      t_d;
  logic [RW-1:0]   retry_d;

  assign state_change = (next_state != state);

  // Restarting the FSM prescaler on every transition makes N ms exactly N*TICK_DIV cycles.
  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_fsm_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_change),
    .en   (1'b1),
    .tick (fsm_tick)
  );

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_period_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (!auto_en),
    .en   (auto_en),
    .tick (p_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      ms_cnt <= '0;
    end else if (state_change) begin
      ms_cnt <= '0;
    end else if (fsm_tick) begin
      ms_cnt <= ms_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      p_ms <= '0;
    end else if (!auto_en) begin
      p_ms <= '0;
    end else if (p_tick) begin
      p_ms <= period_fire ? '0 : p_ms + 1'b1;
    end
  end

  assign period_fire = p_tick && (p_ms == PERIOD_END);
  assign gap_done    = (state == GAP)  && fsm_tick && (ms_cnt == GAP_END);
  assign timeout     = (state == WAIT) && fsm_tick && (ms_cnt == TMO_END);
  assign good_read   = (state == WAIT) && dht11_done && dht11_valid;
  // A done pulse in the same cycle as the timeout takes precedence over it.
  assign bad_read    = (state == WAIT) && ((dht11_done && !dht11_valid) || (!dht11_done && timeout));
  assign can_retry   = (retry_cnt < RETRY_MAX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= GAP;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pending) next_state = START;
      START:   next_state = WAIT;
      WAIT:    if (good_read || bad_read) next_state = GAP;
      GAP:     if (gap_done) next_state = IDLE;
      default: next_state = GAP;
    endcase
  end

  always_comb begin
    start_d   = (next_state == START);
    busy_d    = (next_state != IDLE);
    new_d     = good_read;
    rh_d      = good_read ? rh_in : rh_data;
    t_d       = good_read ? t_in  : t_data;
    valid_d   = data_valid || good_read;
    err_d     = err_flag;
    retry_d   = retry_cnt;
    pending_d = pending || manual_req || period_fire;

    if (good_read) begin
      err_d   = 1'b0;
      retry_d = '0;
    end else if (bad_read) begin
      if (can_retry) begin
        retry_d   = retry_cnt + 1'b1;
        pending_d = 1'b1;
      end else begin
        err_d   = 1'b1;
        retry_d = '0;
      end
    end

    // Entering START consumes every request collected so far.
    if (next_state == START && state != START) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dht11_start <= 1'b0;
      busy        <= 1'b1;
      new_data    <= 1'b0;
      rh_data     <= '0;
      t_data      <= '0;
      data_valid  <= 1'b0;
      err_flag    <= 1'b0;
      retry_cnt   <= '0;
      pending     <= 1'b0;
    end else begin
      dht11_start <= start_d;
      busy        <= busy_d;
      new_data    <= new_d;
      rh_data     <= rh_d;
      t_data      <= t_d;
      data_valid  <= valid_d;
      err_flag    <= err_d;
      retry_cnt   <= retry_d;
      pending     <= pending_d;
    end
  end

endmodule

// File: tb/tb_dht11_scheduler.sv
// Directed self-checking bench for dht11_scheduler with shortened timing parameters.
module tb_dht11_scheduler;

  localparam int TICK_DIV   = 10;
  localparam int PERIOD_MS  = 20;
  localparam int GAP_MS     = 3;
  localparam int TIMEOUT_MS = 5;
  localparam int MAX_RETRY  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       manual_req = 1'b0;
  logic       auto_en = 1'b0;
  logic       dht11_done = 1'b0;
  logic       dht11_valid = 1'b0;
  logic [7:0] rh_in = 8'h00;
  logic [7:0] t_in = 8'h00;

  logic       dht11_start;
  logic [7:0] rh_data;
  logic [7:0] t_data;
  logic       data_valid;
  logic       new_data;
  logic       err_flag;
  logic [1:0] retry_cnt;
  logic       busy;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  dht11_scheduler #(
    .TICK_DIV   (TICK_DIV),
    .PERIOD_MS  (PERIOD_MS),
    .GAP_MS     (GAP_MS),
    .TIMEOUT_MS (TIMEOUT_MS),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .manual_req  (manual_req),
    .auto_en     (auto_en),
    .dht11_done  (dht11_done),
    .dht11_valid (dht11_valid),
    .rh_in       (rh_in),
    .t_in        (t_in),
    .dht11_start (dht11_start),
    .rh_data     (rh_data),
    .t_data      (t_data),
    .data_valid  (data_valid),
    .new_data    (new_data),
    .err_flag    (err_flag),
    .retry_cnt   (retry_cnt),
    .busy        (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic m, input logic d, input logic v,
                               input logic [7:0] rh, input logic [7:0] t);
    manual_req  = m;
    dht11_done  = d;
    dht11_valid = v;
    rh_in       = rh;
    t_in        = t;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_start"}, 32'(dht11_start), 32'd0);
    checkOutput({tag, "_rh"},    32'(rh_data),     32'd0);
    checkOutput({tag, "_t"},     32'(t_data),      32'd0);
    checkOutput({tag, "_valid"}, 32'(data_valid),  32'd0);
    checkOutput({tag, "_new"},   32'(new_data),    32'd0);
    checkOutput({tag, "_err"},   32'(err_flag),    32'd0);
    checkOutput({tag, "_retry"}, 32'(retry_cnt),   32'd0);
    checkOutput({tag, "_busy"},  32'(busy),        32'd1);
  endtask

  task automatic waitStart(input int budget, output int n, output logic seen);
    n = 0;
    while (dht11_start !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    seen = (dht11_start === 1'b1);
  endtask

  task automatic expectStart(input string tag, input int exp_n);
    int   n;
    logic seen;
    waitStart(exp_n + 20, n, seen);
    checkOutput({tag, "_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_lat"},  32'(n),    32'(exp_n));
  endtask

  task automatic answer(input logic v, input logic [7:0] rh, input logic [7:0] t);
    step();
    applyStimulus(1'b0, 1'b1, v, rh, t);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic pulseManual();
    manual_req = 1'b1;
    step();
    manual_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   r0;
    int   viol;
    int   s1;
    int   n;
    logic seen;

    // Power-up holdoff with an early manual request
    repeat (3) step();
    rst = 1'b1;
    r0 = cyc;
    checkReset("reset");
    viol = 0;
    for (int k = 1; k <= 29; k++) begin
      step();
      if (k == 1) manual_req = 1'b1;
      if (k == 2) manual_req = 1'b0;
      if (busy !== 1'b1 || dht11_start !== 1'b0) viol++;
    end
    checkOutput("holdoff_violations", 32'(viol), 32'd0);
    expectStart("powerup", 2);
    checkOutput("powerup_edge", 32'(cyc - r0), 32'd31);

    // Good read and the gap that follows it
    answer(1'b1, 8'h37, 8'h19);
    checkOutput("good_rh",    32'(rh_data),    32'h37);
    checkOutput("good_t",     32'(t_data),     32'h19);
    checkOutput("good_new",   32'(new_data),   32'd1);
    checkOutput("good_valid", 32'(data_valid), 32'd1);
    checkOutput("good_err",   32'(err_flag),   32'd0);
    step();
    checkOutput("good_new_pulse", 32'(new_data), 32'd0);
    pulseManual();
    expectStart("good_gap", 29);

    // Checksum failures: two retries, then error
    answer(1'b0, 8'hAA, 8'hBB);
    checkOutput("fail1_retry", 32'(retry_cnt), 32'd1);
    checkOutput("fail1_err",   32'(err_flag),  32'd0);
    checkOutput("fail1_rh",    32'(rh_data),   32'h37);
    checkOutput("fail1_new",   32'(new_data),  32'd0);
    expectStart("retry1", 31);
    answer(1'b0, 8'hAA, 8'hBB);
    checkOutput("fail2_retry", 32'(retry_cnt), 32'd2);
    expectStart("retry2", 31);
    answer(1'b0, 8'hAA, 8'hBB);
    checkOutput("fail3_err",   32'(err_flag),  32'd1);
    checkOutput("fail3_retry", 32'(retry_cnt), 32'd0);
    checkOutput("fail3_rh",    32'(rh_data),   32'h37);
    checkOutput("fail3_t",     32'(t_data),    32'h19);
    pulseManual();
    expectStart("after_err", 30);
    answer(1'b1, 8'h40, 8'h15);
    checkOutput("recover_err", 32'(err_flag), 32'd0);
    checkOutput("recover_rh",  32'(rh_data),  32'h40);
    checkOutput("recover_t",   32'(t_data),   32'h15);

    // Timeout with no done pulse
    step();
    pulseManual();
    expectStart("pre_timeout", 29);
    step();
    repeat (49) step();
    checkOutput("timeout_early_retry", 32'(retry_cnt), 32'd0);
    checkOutput("timeout_early_busy",  32'(busy),      32'd1);
    step();
    checkOutput("timeout_retry", 32'(retry_cnt), 32'd1);
    expectStart("timeout_restart", 31);
    answer(1'b1, 8'h41, 8'h16);
    checkOutput("timeout_recover_retry", 32'(retry_cnt), 32'd0);

    // Auto schedule with coalesced manual requests
    auto_en = 1'b1;
    expectStart("auto_first", 201);
    s1 = cyc;
    step();
    manual_req = 1'b1; step();
    manual_req = 1'b0; step();
    manual_req = 1'b1; step();
    manual_req = 1'b0; step();
    manual_req = 1'b1; step();
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h42, 8'h17);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("auto_rh", 32'(rh_data), 32'h42);
    expectStart("coalesced", 31);
    answer(1'b1, 8'h43, 8'h18);
    expectStart("auto_second", 160);
    checkOutput("auto_period", 32'(cyc - s1), 32'd200);
    answer(1'b1, 8'h44, 8'h19);
    auto_en = 1'b0;
    waitStart(450, n, seen);
    checkOutput("auto_off_no_start", 32'(seen), 32'd0);

    // Reset in the middle of a transaction
    pulseManual();
    expectStart("idle_latency", 1);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    checkReset("midreset");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h55, 8'h66);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("late_done_rh",    32'(rh_data),    32'd0);
    checkOutput("late_done_new",   32'(new_data),   32'd0);
    checkOutput("late_done_valid", 32'(data_valid), 32'd0);
    pulseManual();
    expectStart("reset_holdoff", 29);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dht11_scheduler.md
Name: dht11_scheduler

Overview:
- Measurement sequencer in front of dht11_controller.
- Issues start pulses on a periodic auto schedule or on manual request, and enforces the sensor's minimum inter-read gap, including a power-up holdoff.
- Applies a transaction timeout, retries failed reads, and holds the last good RH/T bytes for fnd_controller and any other consumer.
- Sits between btn_debounce_sw / system logic and dht11_controller.

Parameters:
- TICK_DIV, 100_000: clk cycles per 1 ms tick (100 MHz). Benches use 10.
- PERIOD_MS, 2000: auto-measurement period in ms.
- GAP_MS, 1000: minimum holdoff after any transaction, and after reset.
- TIMEOUT_MS, 50: maximum wait for dht11_done after a start.
- MAX_RETRY, 3: retries after a failed read before err_flag is raised.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-low reset.
- manual_req, input, 1: one-cycle request pulse from the debounced button.
- auto_en, input, 1: enables the periodic schedule.
- dht11_done, input, 1: one-cycle transaction-end pulse from dht11_controller.
- dht11_valid, input, 1: checksum-OK qualifier, sampled with dht11_done.
- rh_in, input, 8: RH integer byte from dht11_controller.
- t_in, input, 8: T integer byte from dht11_controller.
- dht11_start, output, 1: one-cycle start pulse to dht11_controller.
- rh_data, output, 8: last good RH value.
- t_data, output, 8: last good T value.
- data_valid, output, 1: sticky; set by the first good read.
- new_data, output, 1: one-cycle pulse when rh_data/t_data update.
- err_flag, output, 1: retries exhausted; cleared by the next good read.
- retry_cnt, output, $clog2(MAX_RETRY+1): current retry count.
- busy, output, 1: high whenever the state is not IDLE.

Behaviour:
- Reset (rst=0 at an edge):
  - state=GAP; gap timer and prescaler cleared; pending=0; period timer cleared.
  - dht11_start=0, rh_data=0, t_data=0, data_valid=0, new_data=0, err_flag=0, retry_cnt=0, busy=1.
  - Reset mid-transaction abandons it; no start pulse is issued until GAP_MS has elapsed.
- ms tick prescaler:
  - Counts 0..TICK_DIV-1; tick is asserted on the terminal count.
  - Cleared on every state transition, so GAP and TIMEOUT durations are exact: N ms = N*TICK_DIV cycles after state entry.
- Period timer:
  - Has its own prescaler; runs only while auto_en=1 and is held at 0 when auto_en=0.
  - At PERIOD_MS it sets pending and restarts. Runs in every state.
- Pending flag:
  - Set by manual_req or the period timer; cleared on entry to START.
  - Multiple requests coalesce into one transaction.
- IDLE: pending=1 -> START.
- START:
  - dht11_start=1 for exactly this one cycle; pending cleared; go to WAIT.
  - Latency: manual_req sampled at edge k in IDLE -> dht11_start high in the cycle after edge k+1.
- WAIT:
  - dht11_done & dht11_valid:
    - Latch rh_in/t_in into rh_data/t_data; new_data=1 for one cycle; data_valid=1; err_flag=0; retry_cnt=0 -> GAP.
  - (dht11_done & !dht11_valid) or TIMEOUT_MS elapsed:
    - If retry_cnt<MAX_RETRY: retry_cnt+1, set pending -> GAP.
    - Else: err_flag=1, retry_cnt=0, pending unchanged -> GAP.
  - dht11_done and timeout in the same cycle: dht11_done wins.
  - A dht11_done seen outside WAIT is ignored.
- GAP: after GAP_MS -> IDLE.
- Requests arriving in START/WAIT/GAP are latched in pending and serviced after the gap.
- A failed read never changes rh_data or t_data.
- All outputs are registered.

Decomposition:
- dht11_pkg holds:
  - state encodings: IDLE=2'd0, START=2'd1, WAIT=2'd2, GAP=2'd3;
  - default timing constants (TICK_DIV, PERIOD_MS, GAP_MS, TIMEOUT_MS, MAX_RETRY).
- One natural sub-module, ms_tick_gen: prescaler with a synchronous clear and a tick output.
  - Instantiated twice: once for the FSM timer and once for the period timer.

Test Plan:
All scenarios use TICK_DIV=10, GAP_MS=3, TIMEOUT_MS=5, PERIOD_MS=20, MAX_RETRY=2.
- Power-up holdoff: release reset, then pulse manual_req at cycle 2 -> no dht11_start before cycle 30; start issued once, 2 cycles after GAP->IDLE; busy=1 throughout.
- Good read: after a start, drive done=1, valid=1, rh_in=0x37, t_in=0x19 -> next cycle rh_data=0x37, t_data=0x19, new_data pulses once, data_valid=1; next start is not earlier than 30 cycles later.
- Retry then error: answer 3 successive starts with done=1, valid=0 -> retry_cnt 1, 2, then err_flag=1 with retry_cnt=0; rh_data/t_data unchanged; a subsequent good read clears err_flag.
- Timeout: after a start, never assert done -> exactly 50 cycles after WAIT entry, retry_cnt=1 and a retry start follows the gap.
- Auto + coalescing: auto_en=1 plus 3 manual_req pulses during WAIT -> exactly one extra start after the gap; periodic starts continue every ≥200 cycles; auto_en=0 stops them.
- Reset mid-WAIT: rst=0 for 1 cycle -> all outputs return to reset values; a late dht11_done is ignored; no start for 30 cycles.
